sa_output_drain: RTL and testbench

- Downstream stage of the systolic array (SA). Times an accumulation window after a start pulse.
- At the end of the window it snapshots the flattened SA result bus Y into a shadow bank.
- It then streams the bank out one PE row per beat over a valid/ready interface, so the SA can be reused while results drain.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_row_mux.sv | 30 +++
 rtl/sa_output_drain.sv | 134 +++++++++++++
 tb/tb_sa_output_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array output drain.
// State encoding, result width and the Y bus block-index mapping.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN
  } state_t;

  localparam int SA_WIDTH = 8;
  localparam int RES_W    = 2 * SA_WIDTH;

  // Block index of element (r,c) in the flattened Y bus; (0,0) is MSB.
  function automatic int blk_idx(
    input int r,
    input int c,
    input int hpe,
    input int vpe
  );
    return hpe * vpe - 1 - (r * hpe + c);
  endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Selects one PE row out of a flattened result bank.
// Ports: bank (all results), row (index), row_data (HPE results, col 0 in LSBs).
module sa_row_mux
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int HPE   = 2,
  parameter int VPE   = 2,
  parameter int RW    = 1
) (
  input  logic [2*WIDTH*HPE*VPE-1:0] bank,
  input  logic [RW-1:0]              row,
  output logic [2*WIDTH*HPE-1:0]     row_data
);

  localparam int RES = 2 * WIDTH;

  always_comb begin
    row_data = '0;
    for (int r = 0; r < VPE; r++) begin
      if (row == RW'(r)) begin
        for (int c = 0; c < HPE; c++) begin
          row_data[c*RES +: RES] =
            bank[blk_idx(r, c, HPE, VPE)*RES +: RES];
        end
      end
    end
  end

endmodule

// File: rtl/sa_output_drain.sv
// Times an accumulation window, snapshots Y, then drains it row by row.
// Ports: CLK/RST, start/k_len, Y in; out_* valid/ready stream, busy, start_err.
module sa_output_drain
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int HPE   = 2,
  parameter int VPE   = 2,
  parameter int RW    = $clog2(VPE > 1 ? VPE : 2)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [15:0]                k_len,
  input  logic [2*WIDTH*HPE*VPE-1:0] Y,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [2*WIDTH*HPE-1:0]     out_data,
  output logic [RW-1:0]              out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       start_err
);

  localparam int BANK_W = 2 * WIDTH * HPE * VPE;
  localparam int ROW_W  = 2 * WIDTH * HPE;
  localparam logic [RW-1:0] LAST_ROW = RW'(VPE - 1);

  state_t            state, state_d;
  logic [15:0]       cnt, cnt_d;
  logic [BANK_W-1:0] bank;
  logic [RW-1:0]     row;
  logic [ROW_W-1:0]  data_q;
  logic              last_q;
  logic              err_q, err_d;
  logic              cap, adv, fin, hs;
  logic [BANK_W-1:0] mux_bank;
  logic [RW-1:0]     mux_row, row_nxt;
  logic [ROW_W-1:0]  mux_data;

  assign hs      = out_valid & out_ready;
  assign row_nxt = row + RW'(1);

  // Capture edge loads row 0 straight from Y, since bank updates same edge.
  assign mux_bank = cap ? Y : bank;
  assign mux_row  = cap ? '0 : row_nxt;

  sa_row_mux #(
    .WIDTH (WIDTH),
    .HPE   (HPE),
    .VPE   (VPE),
    .RW    (RW)
  ) u_mux (
    .bank     (mux_bank),
    .row      (mux_row),
    .row_data (mux_data)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = err_q;
    cap     = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          cnt_d   = (k_len == 16'd0) ? 16'd0 : k_len - 16'd1;
        end
      end
      COUNT: begin
        if (start) err_d = 1'b1;
        if (cnt == 16'd0) begin
          cap     = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      DRAIN: begin
        if (start) err_d = 1'b1;
        if (hs) begin
          if (row == LAST_ROW) begin
            fin     = 1'b1;
            state_d = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      bank   <= '0;
      row    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (cap) begin
        bank   <= Y;
        row    <= '0;
        data_q <= mux_data;
        last_q <= (LAST_ROW == '0);
      end else if (adv) begin
        row    <= row_nxt;
        data_q <= mux_data;
        last_q <= (row_nxt == LAST_ROW);
      end else if (fin) begin
        row    <= '0;
        data_q <= '0;
        last_q <= 1'b0;
      end
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = data_q;
  assign out_row   = row;
  assign out_last  = last_q;
  assign busy      = (state != IDLE);
  assign start_err = err_q;

endmodule

// File: tb/tb_sa_output_drain.sv
// Self-checking bench for sa_output_drain (WIDTH=8, HPE=VPE=2).
// Vector table plus scoreboarded beats and hand-written corner sequences.
module tb_sa_output_drain;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] k_len = '0;
  logic [63:0] Y = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [0:0]  out_row;
  logic        out_last;
  logic        busy;
  logic        start_err;

  sa_output_drain dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .k_len     (k_len),
    .Y         (Y),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .start_err (start_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic        row;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] k;
    logic [63:0] y;
    int          lat;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[5];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent model of the row layout: (r,c) at block 3-(2r+c).
  function automatic logic [31:0] model_row(input logic [63:0] y,
                                            input int r);
    logic [31:0] d;
    d = '0;
    for (int c = 0; c < 2; c++)
      d[c*16 +: 16] = y[(3 - (r*2 + c))*16 +: 16];
    return d;
  endfunction

  task automatic push_drain(input logic [63:0] y);
    for (int r = 0; r < 2; r++) begin
      beat_t b;
      b.d    = model_row(y, r);
      b.row  = (r == 1);
      b.last = (r == 1);
      sb.push_back(b);
    end
  endtask

  always @(negedge CLK) begin
    if (RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got %0h want none", out_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_row", out_row, e.row);
        check("beat_last", out_last, e.last);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [15:0] k, input logic [63:0] y);
    k_len = k;
    Y     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got timeout want out_valid");
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got timeout want busy=0");
    end
  endtask

  task automatic pulse_reset;
    RST = 1'b0;
    #1;
    check("rst_start_err", start_err, 0);
    tick();
    RST = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    int cyc;
    logic [63:0] yv;

    vecs[0] = '{16'd3, 64'h0004_0003_0002_0001, 3,
                32'h0003_0004, 32'h0001_0002};
    vecs[1] = '{16'd0, 64'hAAAA_BBBB_CCCC_DDDD, 1,
                32'hBBBB_AAAA, 32'hDDDD_CCCC};
    vecs[2] = '{16'd1, 64'hAAAA_BBBB_CCCC_DDDD, 1,
                32'hBBBB_AAAA, 32'hDDDD_CCCC};
    vecs[3] = '{16'd7, 64'h1234_5678_9ABC_DEF0, 7,
                32'h5678_1234, 32'hDEF0_9ABC};
    vecs[4] = '{16'd2, 64'h8000_0001_7FFF_FFFE, 2,
                32'h0001_8000, 32'hFFFE_7FFF};

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_last", out_last, 0);
    check("rst_err", start_err, 0);
    tick();
    RST = 1'b1;
    tick();

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      do_start(vecs[i].k, vecs[i].y);
      push_drain(vecs[i].y);
      check("busy_after_start", busy, 1);
      wait_valid(lat);
      check("latency", lat, vecs[i].lat);
      Y = ~vecs[i].y;
      check("vec_d0", out_data, vecs[i].d0);
      check("vec_row0", out_row, 0);
      check("vec_last0", out_last, 0);
      tick();
      check("vec_d1", out_data, vecs[i].d1);
      check("vec_row1", out_row, 1);
      check("vec_last1", out_last, 1);
      tick();
      check("vec_busy_end", busy, 0);
      check("vec_valid_end", out_valid, 0);
      check("vec_data_end", out_data, 0);
      check("vec_sb_empty", sb.size(), 0);
      check("vec_err", start_err, 0);
    end

    out_ready = 1'b0;
    yv = 64'h0004_0003_0002_0001;
    do_start(16'd2, yv);
    push_drain(yv);
    wait_valid(lat);
    Y = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h0003_0004);
      check("bp_row", out_row, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle(cyc);
    check("bp_sb_empty", sb.size(), 0);

    yv = 64'h1111_2222_3333_4444;
    do_start(16'd1, yv);
    push_drain(yv);
    wait_valid(lat);
    tick();
    check("fh_row1", out_row, 1);
    k_len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fh_err", start_err, 1);
    check("fh_busy", busy, 0);
    check("fh_valid", out_valid, 0);
    repeat (4) tick();
    check("fh_busy_later", busy, 0);
    check("fh_sb_empty", sb.size(), 0);
    check("fh_err_sticky", start_err, 1);

    pulse_reset();
    yv = 64'h0F0F_F0F0_00FF_FF00;
    do_start(16'd4, yv);
    push_drain(yv);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cnt_err", start_err, 1);
    check("cnt_busy", busy, 1);
    wait_valid(lat);
    check("cnt_latency", lat, 2);
    wait_idle(cyc);
    check("cnt_sb_empty", sb.size(), 0);
    check("cnt_err_sticky", start_err, 1);

    pulse_reset();
    yv = 64'hA1A1_B2B2_C3C3_D4D4;
    do_start(16'd1, yv);
    push_drain(yv);
    wait_idle(cyc);
    yv = 64'h5555_6666_7777_8888;
    do_start(16'd2, yv);
    push_drain(yv);
    check("b2b_busy", busy, 1);
    check("b2b_err", start_err, 0);
    wait_valid(lat);
    check("b2b_latency", lat, 2);
    check("b2b_d0", out_data, 32'h6666_5555);
    wait_idle(cyc);
    check("b2b_sb_empty", sb.size(), 0);
    check("b2b_err_end", start_err, 0);

    out_ready = 1'b0;
    yv = 64'h9999_AAAA_BBBB_CCCC;
    do_start(16'd1, yv);
    push_drain(yv);
    wait_valid(lat);
    check("mid_valid", out_valid, 1);
    #2;
    RST = 1'b0;
    #1;
    check("mid_valid_rst", out_valid, 0);
    check("mid_busy_rst", busy, 0);
    check("mid_data_rst", out_data, 0);
    check("mid_row_rst", out_row, 0);
    check("mid_last_rst", out_last, 0);
    sb.delete();
    tick();
    RST = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      tick();
      check("post_rst_idle", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
